// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller: same-cycle hit service, dirty writeback, line refill, tag clear after reset.
// Hits complete with zero latency; misses and the post-reset tag sweep hold cpu_stall_o until the line is resident.
module dcache_ctrl #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 22,
  parameter int LINE_W  = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [31:0]         cpu_addr_i,
  input  logic [31:0]         cpu_data_i,
  output logic [31:0]         cpu_data_o,
  output logic                cpu_stall_o,
  output logic                tag_enable_o,
  output logic                tag_write_o,
  output logic [INDEX_W-1:0]  tag_addr_o,
  output logic [TAG_W+1:0]    tag_data_o,
  input  logic [TAG_W+1:0]    tag_data_i,
  output logic                data_enable_o,
  output logic                data_write_o,
  output logic [INDEX_W-1:0]  data_addr_o,
  output logic [LINE_W-1:0]   data_data_o,
  input  logic [LINE_W-1:0]   data_data_i,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [31:0]         mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
);
  localparam int OFF_W  = 32 - TAG_W - INDEX_W;
  localparam int WSEL_W = $clog2(LINE_W / 32);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITEBACK, S_ALLOCATE, S_REFILL} state_t;

  state_t              r_state, w_next;
  logic [INDEX_W-1:0]  r_cnt, r_index;
  logic [TAG_W-1:0]    r_req_tag, r_victim_tag;
  logic [LINE_W-1:0]   r_line;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [WSEL_W-1:0]   w_word;
  logic                w_hit, w_miss, w_dirty_victim, w_unused;
  logic [31:0]         w_rd_word;
  logic [LINE_W-1:0]   w_merged;

  assign w_tag          = cpu_addr_i[31 -: TAG_W];
  assign w_index        = cpu_addr_i[OFF_W +: INDEX_W];
  assign w_word         = cpu_addr_i[2 +: WSEL_W];
  assign w_unused       = ^cpu_addr_i[1:0];
  assign w_hit          = tag_data_i[TAG_W+1] && (tag_data_i[TAG_W-1:0] == w_tag);
  assign w_miss         = cpu_req_i && !w_hit;
  assign w_dirty_victim = tag_data_i[TAG_W+1] && tag_data_i[TAG_W];
  assign w_rd_word      = data_data_i[{w_word, 5'b0} +: 32];

  always_comb begin
    w_merged = data_data_i;
    w_merged[{w_word, 5'b0} +: 32] = cpu_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  // Miss context is frozen at the IDLE->miss edge so the CPU may drop or change its request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt        <= '0;
      r_index      <= '0;
      r_req_tag    <= '0;
      r_victim_tag <= '0;
      r_line       <= '0;
    end else begin
      if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_IDLE && w_miss) begin
        r_index      <= w_index;
        r_req_tag    <= w_tag;
        r_victim_tag <= tag_data_i[TAG_W-1:0];
      end
      if (r_state == S_ALLOCATE && mem_ack_i) r_line <= mem_data_i;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:      if (&r_cnt) w_next = S_IDLE;
      S_IDLE:      if (w_miss) w_next = w_dirty_victim ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: if (mem_ack_i) w_next = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ack_i) w_next = S_REFILL;
      S_REFILL:    w_next = S_IDLE;
      default:     w_next = S_INIT;
    endcase
  end

  always_comb begin
    cpu_stall_o   = 1'b1;
    cpu_data_o    = '0;
    tag_enable_o  = 1'b0;
    tag_write_o   = 1'b0;
    tag_addr_o    = r_index;
    tag_data_o    = '0;
    data_enable_o = 1'b0;
    data_write_o  = 1'b0;
    data_addr_o   = r_index;
    data_data_o   = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    case (r_state)
      // Gating with rst_i keeps the sweep from writing while reset is still held.
      S_INIT: begin
        tag_enable_o = rst_i;
        tag_write_o  = rst_i;
        tag_addr_o   = r_cnt;
      end
      S_IDLE: begin
        tag_addr_o    = w_index;
        data_addr_o   = w_index;
        tag_enable_o  = cpu_req_i;
        data_enable_o = cpu_req_i;
        cpu_stall_o   = w_miss;
        if (cpu_req_i && w_hit) begin
          if (cpu_we_i) begin
            tag_write_o  = 1'b1;
            data_write_o = 1'b1;
            tag_data_o   = {2'b11, w_tag};
            data_data_o  = w_merged;
          end else begin
            cpu_data_o = w_rd_word;
          end
        end
      end
      S_WRITEBACK: begin
        data_enable_o = 1'b1;
        mem_enable_o  = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = {r_victim_tag, r_index, {OFF_W{1'b0}}};
        mem_data_o    = data_data_i;
      end
      S_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {r_req_tag, r_index, {OFF_W{1'b0}}};
      end
      S_REFILL: begin
        tag_enable_o  = 1'b1;
        tag_write_o   = 1'b1;
        data_enable_o = 1'b1;
        data_write_o  = 1'b1;
        tag_data_o    = {2'b10, r_req_tag};
        data_data_o   = r_line;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural SRAMs and memory, plus a cache-semantics reference model.
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i, cpu_req_i, cpu_we_i, mem_ack_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o, mem_addr_o;
  logic         cpu_stall_o, tag_enable_o, tag_write_o, data_enable_o, data_write_o, mem_enable_o, mem_write_o;
  logic [4:0]   tag_addr_o, data_addr_o;
  logic [23:0]  tag_data_o, tag_data_i;
  logic [255:0] data_data_o, data_data_i, mem_data_o, mem_data_i;

  int checks = 0;
  int errors = 0;
  bit scramble = 1'b0;

  logic [23:0]  tag_mem  [32];
  logic [255:0] data_mem [32];
  logic [255:0] bus_mem  [logic [31:0]];
  logic [255:0] exp_mem  [logic [31:0]];
  bit           ref_valid [32];
  bit           ref_dirty [32];
  logic [21:0]  ref_tag   [32];
  logic [255:0] ref_line  [32];

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .tag_enable_o(tag_enable_o), .tag_write_o(tag_write_o), .tag_addr_o(tag_addr_o),
    .tag_data_o(tag_data_o), .tag_data_i(tag_data_i),
    .data_enable_o(data_enable_o), .data_write_o(data_write_o), .data_addr_o(data_addr_o),
    .data_data_o(data_data_o), .data_data_i(data_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = a ^ {8'(w), 24'hC0FFEE};
    return l;
  endfunction

  function automatic logic [255:0] bus_line(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_line(a);
  endfunction

  // SRAMs: write on the falling edge, read combinationally.
  always @(negedge clk_i) begin
    if (scramble) begin
      for (int i = 0; i < 32; i++) begin
        tag_mem[i]  <= {2'b11, 22'($urandom())};
        data_mem[i] <= rand_line();
      end
    end else begin
      if (tag_enable_o && tag_write_o)   tag_mem[tag_addr_o]   <= tag_data_o;
      if (data_enable_o && data_write_o) data_mem[data_addr_o] <= data_data_o;
    end
  end
  assign tag_data_i  = tag_mem[tag_addr_o];
  assign data_data_i = data_mem[data_addr_o];

  task automatic ref_clear();
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endtask

  task automatic ref_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            output bit e_wb, output logic [31:0] e_wb_addr, output logic [255:0] e_wb_line,
                            output bit e_fetch, output logic [31:0] e_fetch_addr, output logic [31:0] e_rdata);
    int idx, w;
    logic [21:0] t;
    idx = int'(addr[9:5]);
    w = int'(addr[4:2]);
    t = addr[31:10];
    e_wb = 1'b0; e_wb_addr = '0; e_wb_line = '0; e_fetch = 1'b0; e_fetch_addr = '0;
    if (!(ref_valid[idx] && ref_tag[idx] == t)) begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        e_wb = 1'b1;
        e_wb_addr = {ref_tag[idx], addr[9:5], 5'b0};
        e_wb_line = ref_line[idx];
        exp_mem[e_wb_addr] = ref_line[idx];
      end
      e_fetch = 1'b1;
      e_fetch_addr = {t, addr[9:5], 5'b0};
      ref_line[idx] = exp_line(e_fetch_addr);
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
      ref_tag[idx] = t;
    end
    e_rdata = ref_line[idx][w*32 +: 32];
    if (we) begin
      ref_line[idx][w*32 +: 32] = wd;
      ref_dirty[idx] = 1'b1;
    end
  endtask

  // Drives one CPU access and plays the memory side; ack arrives on the ackw/acka-th cycle of a request.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int ackw, input int acka, input int drop_at,
                        output logic [31:0] rdata, output int lat, output int nwb,
                        output logic [31:0] wb_addr, output logic [255:0] wb_line,
                        output int nfetch, output logic [31:0] fetch_addr,
                        output int unstable, output bit timeout);
    int tcnt;
    logic [31:0] taddr;
    logic twr;
    bit done;
    rdata = '0; lat = 0; nwb = 0; wb_addr = '0; wb_line = '0; nfetch = 0; fetch_addr = '0;
    unstable = 0; timeout = 1'b0; tcnt = 0; taddr = '0; twr = 1'b0; done = 1'b0;
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wd; mem_ack_i = 1'b0;
    #1;
    for (int k = 0; k < 400 && !done; k++) begin
      if (k > 0) begin
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        mem_data_i = rand_line();
        if (k == drop_at) cpu_req_i = 1'b0;
        #1;
      end
      if (!cpu_stall_o) begin
        done = 1'b1;
        rdata = cpu_data_o;
        lat = k;
      end else if (mem_enable_o) begin
        tcnt++;
        if (tcnt == 1) begin
          taddr = mem_addr_o;
          twr = mem_write_o;
          if (mem_write_o) begin
            nwb++; wb_addr = mem_addr_o; wb_line = mem_data_o;
          end else begin
            nfetch++; fetch_addr = mem_addr_o;
          end
        end else if (mem_addr_o !== taddr || mem_write_o !== twr) begin
          unstable++;
        end
        if (tcnt == (twr ? ackw : acka)) begin
          if (twr) bus_mem[mem_addr_o] = mem_data_o;
          else     mem_data_i = bus_line(mem_addr_o);
          mem_ack_i = 1'b1;
          tcnt = 0;
        end
      end
    end
    if (!done) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    scramble = 1'b1;
    @(negedge clk_i); #1;
    scramble = 1'b0;
    rst_i = 1'b0;
    #1;
    checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", cpu_stall_o); end
    checks++; if ({mem_enable_o, mem_write_o, tag_write_o, data_write_o} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {mem_enable_o, mem_write_o, tag_write_o, data_write_o}); end
    checks++; if (cpu_data_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) begin
      errors++; $display("FAIL reset_data: cpu_data %h mem_addr %h expected 0", cpu_data_o, mem_addr_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) begin @(posedge clk_i); #2; end
      if (k < 32) begin
        checks++;
        if (cpu_stall_o !== 1'b1 || tag_write_o !== 1'b1 || tag_addr_o !== 5'(k) || tag_data_o !== 24'h0) begin
          errors++;
          $display("FAIL init_sweep[%0d]: stall %b wr %b addr %0d data %h expected 1 1 %0d 000000",
                   k, cpu_stall_o, tag_write_o, tag_addr_o, tag_data_o, k);
        end
      end else begin
        checks++;
        if (cpu_stall_o !== 1'b0 || tag_write_o !== 1'b0) begin
          errors++; $display("FAIL init_done: stall %b wr %b expected 0 0", cpu_stall_o, tag_write_o);
        end
      end
    end
    begin
      int nz = 0;
      for (int i = 0; i < 32; i++) if (tag_mem[i] !== 24'h0) nz++;
      checks++; if (nz != 0) begin errors++; $display("FAIL init_cleared: %0d nonzero entries expected 0", nz); end
    end
    ref_clear();
  endtask

  task automatic test_cold_load();
    logic [255:0] l;
    logic [31:0] rd, wa, fa, er, ewa, efa;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un;
    bit to, ewb, ef;
    l = init_line(32'h400);
    l[63:32] = 32'hDEAD_BEEF;
    bus_mem[32'h400] = l;
    exp_mem[32'h400] = l;
    ref_access(1'b0, 32'h404, 32'h0, ewb, ewa, ewl, ef, efa, er);
    access(1'b0, 32'h404, 32'h0, 1, 5, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
    checks++; if (to || nf != 1 || nwb != 0 || fa !== 32'h400) begin
      errors++; $display("FAIL cold_fetch: fetches %0d wbs %0d addr %h expected 1 0 00000400", nf, nwb, fa); end
    checks++; if (rd !== 32'hDEAD_BEEF || rd !== er) begin errors++; $display("FAIL cold_data: got %h expected deadbeef", rd); end
    checks++; if (lat != 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", lat); end
    checks++; if (tag_mem[0] !== {2'b10, 22'h1} || data_mem[0] !== l) begin
      errors++; $display("FAIL cold_refill: tag %h expected %h", tag_mem[0], {2'b10, 22'h1}); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd, wa, fa, er, ewa, efa;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un;
    bit to, ewb, ef;
    ref_access(1'b1, 32'h408, 32'h1234_5678, ewb, ewa, ewl, ef, efa, er);
    access(1'b1, 32'h408, 32'h1234_5678, 1, 1, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
    checks++; if (to || lat != 0 || nf != 0) begin errors++; $display("FAIL store_hit_stall: latency %0d fetches %0d expected 0 0", lat, nf); end
    @(negedge clk_i); #1;
    checks++; if (tag_mem[0] !== {2'b11, 22'h1}) begin errors++; $display("FAIL store_tag: got %h expected %h", tag_mem[0], {2'b11, 22'h1}); end
    checks++; if (data_mem[0] !== ref_line[0]) begin errors++; $display("FAIL store_line: got %h expected %h", data_mem[0], ref_line[0]); end
    ref_access(1'b0, 32'h408, 32'h0, ewb, ewa, ewl, ef, efa, er);
    access(1'b0, 32'h408, 32'h0, 1, 1, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
    checks++; if (to || lat != 0 || rd !== 32'h1234_5678) begin errors++; $display("FAIL store_readback: got %h latency %0d expected 12345678 0", rd, lat); end
  endtask

  task automatic test_dirty_miss();
    logic [31:0] rd, wa, fa, er, ewa, efa;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un;
    bit to, ewb, ef;
    ref_access(1'b0, 32'h800, 32'h0, ewb, ewa, ewl, ef, efa, er);
    access(1'b0, 32'h800, 32'h0, 3, 2, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
    checks++; if (to || nwb != 1 || wa !== 32'h400) begin errors++; $display("FAIL wb_addr: count %0d addr %h expected 1 00000400", nwb, wa); end
    checks++; if (wl !== ewl || wl[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL wb_line: got %h expected %h", wl, ewl); end
    checks++; if (nf != 1 || fa !== 32'h800) begin errors++; $display("FAIL dirty_fetch: count %0d addr %h expected 1 00000800", nf, fa); end
    checks++; if (lat != 7 || rd !== er) begin errors++; $display("FAIL dirty_result: latency %0d data %h expected 7 %h", lat, rd, er); end
    checks++; if (tag_mem[0] !== {2'b10, 22'h2}) begin errors++; $display("FAIL dirty_tag: got %h expected %h", tag_mem[0], {2'b10, 22'h2}); end
  endtask

  task automatic test_long_allocate();
    logic [31:0] rd, wa, fa, er, ewa, efa;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un;
    bit to, ewb, ef;
    ref_access(1'b0, 32'h1C20, 32'h0, ewb, ewa, ewl, ef, efa, er);
    access(1'b0, 32'h1C20, 32'h0, 1, 21, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
    checks++; if (to || un != 0 || nf != 1 || fa !== 32'h1C20) begin
      errors++; $display("FAIL long_alloc_hold: unstable %0d fetches %0d addr %h expected 0 1 00001c20", un, nf, fa); end
    checks++; if (lat != 23 || rd !== er) begin errors++; $display("FAIL long_alloc_result: latency %0d data %h expected 23 %h", lat, rd, er); end
  endtask

  task automatic test_req_drop();
    logic [31:0] rd, wa, fa, er, ewa, efa;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un;
    bit to, ewb, ef;
    ref_access(1'b0, 32'h0C40, 32'h0, ewb, ewa, ewl, ef, efa, er);
    access(1'b0, 32'h0C40, 32'h0, 1, 3, 2, rd, lat, nwb, wa, wl, nf, fa, un, to);
    checks++; if (to || nf != 1 || fa !== 32'h0C40) begin errors++; $display("FAIL drop_fetch: count %0d addr %h expected 1 00000c40", nf, fa); end
    @(negedge clk_i); #1;
    checks++; if (tag_mem[2] !== {2'b10, 22'h3} || data_mem[2] !== ref_line[2]) begin
      errors++; $display("FAIL drop_fill: tag %h expected %h", tag_mem[2], {2'b10, 22'h3}); end
  endtask

  task automatic test_ack_ignored();
    logic [31:0] rd, wa, fa, er, ewa, efa;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un;
    bit to, ewb, ef;
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = rand_line();
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    #1;
    checks++; if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL stray_ack: mem_enable %b stall %b expected 0 0", mem_enable_o, cpu_stall_o); end
    ref_access(1'b0, 32'h0C44, 32'h0, ewb, ewa, ewl, ef, efa, er);
    access(1'b0, 32'h0C44, 32'h0, 1, 1, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
    checks++; if (to || lat != 0 || rd !== er) begin errors++; $display("FAIL stray_ack_hit: data %h latency %0d expected %h 0", rd, lat, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wa, fa, er, ewa, efa, a, d;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un, bad;
    bit to, ewb, ef, we;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      we = 1'(i % 2);
      a = {22'h2, 5'd0, 3'($urandom_range(7)), 2'b00};
      d = $urandom();
      ref_access(we, a, d, ewb, ewa, ewl, ef, efa, er);
      access(we, a, d, 1, 1, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
      if (to || lat != 0 || (!we && rd !== er)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL back_to_back: %0d bad accesses expected 0", bad); end
  endtask

  task automatic test_random();
    logic [31:0] rd, wa, fa, er, ewa, efa, a, d;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un, aw, ar, elat;
    bit to, ewb, ef, we;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(1));
      a = {22'($urandom_range(4, 1)), 5'($urandom_range(3)), 3'($urandom_range(7)), 2'($urandom_range(3))};
      d = $urandom();
      aw = $urandom_range(4, 1);
      ar = $urandom_range(4, 1);
      ref_access(we, a, d, ewb, ewa, ewl, ef, efa, er);
      elat = (ewb ? aw : 0) + (ef ? ar + 2 : 0);
      access(we, a, d, aw, ar, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
      checks++; if (to || nwb != int'(ewb) || wa !== ewa || wl !== ewl) begin
        errors++; $display("FAIL rand_wb[%0d]: count %0d addr %h expected %0d %h", i, nwb, wa, ewb, ewa); end
      checks++; if (nf != int'(ef) || fa !== efa) begin
        errors++; $display("FAIL rand_fetch[%0d]: count %0d addr %h expected %0d %h", i, nf, fa, ef, efa); end
      checks++; if (lat != elat || un != 0) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, elat); end
      if (!we) begin
        checks++; if (rd !== er) begin errors++; $display("FAIL rand_load[%0d]: got %h expected %h", i, rd, er); end
      end
    end
  endtask

  task automatic test_reset_mid_wb();
    logic [31:0] rd, wa, fa, er, ewa, efa;
    logic [255:0] wl, ewl;
    int lat, nwb, nf, un, n_stall, n_tw, nz;
    bit to, ewb, ef, seen;
    ref_access(1'b1, 32'h0460, 32'hCAFE_F00D, ewb, ewa, ewl, ef, efa, er);
    access(1'b1, 32'h0460, 32'hCAFE_F00D, 2, 2, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h1060;
    #1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k > 0) begin @(posedge clk_i); #2; end
      if (mem_enable_o && mem_write_o) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_wb_reach: writeback not seen expected 1"); end
    #1;
    rst_i = 1'b0;
    #1;
    checks++; if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || cpu_stall_o !== 1'b1 || tag_write_o !== 1'b0) begin
      errors++; $display("FAIL mid_wb_reset: en %b wr %b stall %b expected 0 0 1", mem_enable_o, mem_write_o, cpu_stall_o); end
    cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    n_stall = 0; n_tw = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin @(posedge clk_i); #2; end
      if (!cpu_stall_o) break;
      n_stall++;
      if (tag_write_o) n_tw++;
    end
    checks++; if (n_stall != 32 || n_tw != 32) begin
      errors++; $display("FAIL mid_wb_resweep: stall %0d writes %0d expected 32 32", n_stall, n_tw); end
    nz = 0;
    for (int i = 0; i < 32; i++) if (tag_mem[i] !== 24'h0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL mid_wb_cleared: %0d nonzero entries expected 0", nz); end
    ref_clear();
    ref_access(1'b0, 32'h0460, 32'h0, ewb, ewa, ewl, ef, efa, er);
    access(1'b0, 32'h0460, 32'h0, 1, 2, -1, rd, lat, nwb, wa, wl, nf, fa, un, to);
    checks++; if (to || nwb != 0 || nf != 1 || rd !== er) begin
      errors++; $display("FAIL post_reset_load: wbs %0d fetches %0d data %h expected 0 1 %h", nwb, nf, rd, er); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_miss();
    test_long_allocate();
    test_req_drop();
    test_ack_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
